// File: rtl/bip_control_if.sv
// Bus between the BIP control unit and its environment: program-memory fetch
// on the input side, datapath steering and status on the output side.
interface bip_control_if #(
  parameter int PC_MSB = 10,
  parameter int CNT_W  = 32
);
  logic              i_start;
  logic [15:0]       i_instr;
  logic [PC_MSB:0]   o_pc;
  logic [PC_MSB:0]   o_operand;
  logic [1:0]        o_sel_a;
  logic              o_sel_b;
  logic              o_op;
  logic              o_wr_acc;
  logic              o_wr_ram;
  logic              o_rd_ram;
  logic              o_halted;
  logic [CNT_W-1:0]  o_cycles;

  modport master (
    input  i_start, i_instr,
    output o_pc, o_operand, o_sel_a, o_sel_b, o_op,
           o_wr_acc, o_wr_ram, o_rd_ram, o_halted, o_cycles
  );

  modport slave (
    output i_start, i_instr,
    input  o_pc, o_operand, o_sel_a, o_sel_b, o_op,
           o_wr_acc, o_wr_ram, o_rd_ram, o_halted, o_cycles
  );
endinterface

// File: rtl/bip_control.sv
// BIP control unit: IDLE/RUN/HALT sequencer with program counter, run-cycle
// counter and single-cycle combinational instruction decode.
module bip_control #(
  parameter int PC_MSB = 10,
  parameter int CNT_W  = 32
) (
  input  logic          clk,
  input  logic          reset,
  bip_control_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  state_t              state_q, state_d;
  logic [PC_MSB:0]     pc_q, pc_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;
  logic [4:0]          opcode;
  logic [1:0]          sel_a;
  logic                sel_b, op, wr_acc, wr_ram, rd_ram;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign opcode = bus.i_instr[15:11];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cycles_q <= cycles_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cycles_d = cycles_q;
    sel_a    = 2'd0;
    sel_b    = 1'b0;
    op       = 1'b0;
    wr_acc   = 1'b0;
    wr_ram   = 1'b0;
    rd_ram   = 1'b0;
    unique case (state_q)
      IDLE, HALT: begin
        if (bus.i_start) begin
          state_d  = RUN;
          pc_d     = '0;
          cycles_d = '0;
        end
      end
      RUN: begin
        // The HLT cycle still counts as an executed cycle; only the PC freezes.
        cycles_d = sat_inc(cycles_q);
        if (opcode == OP_HLT) state_d = HALT;
        else                  pc_d    = pc_q + 1'b1;
        case (opcode)
          OP_STO:  wr_ram = 1'b1;
          OP_LD:   begin rd_ram = 1'b1; wr_acc = 1'b1; end
          OP_LDI:  begin sel_a = 2'd1; wr_acc = 1'b1; end
          OP_ADD:  begin rd_ram = 1'b1; sel_a = 2'd2; op = 1'b1; wr_acc = 1'b1; end
          OP_ADDI: begin sel_a = 2'd2; sel_b = 1'b1; op = 1'b1; wr_acc = 1'b1; end
          OP_SUB:  begin rd_ram = 1'b1; sel_a = 2'd2; wr_acc = 1'b1; end
          OP_SUBI: begin sel_a = 2'd2; sel_b = 1'b1; wr_acc = 1'b1; end
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_pc      = pc_q;
  assign bus.o_cycles  = cycles_q;
  assign bus.o_halted  = (state_q == HALT);
  assign bus.o_operand = bus.i_instr[PC_MSB:0];
  assign bus.o_sel_a   = sel_a;
  assign bus.o_sel_b   = sel_b;
  assign bus.o_op      = op;
  assign bus.o_wr_acc  = wr_acc;
  assign bus.o_wr_ram  = wr_ram;
  assign bus.o_rd_ram  = rd_ram;

endmodule
